// File: rtl/debug_pkg.sv
// Shared constants and helpers for the debug counter bank: mode encodings,
// channel-select width and the per-channel step/init constant.
package debug_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CH_SEL_W = 3;

  // Channel i both starts at and advances by 1 << (i*step_shift), kept inside width bits.
  function automatic logic [63:0] init_val(input int i, input int step_shift, input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'(1) << width) - 64'(1));
    return (64'(1) << (i * step_shift)) & mask;
  endfunction

endpackage

// File: rtl/debug_counter_bank_if.sv
// Read port of the debug counter bank: request/channel in, registered data/valid/error out.
interface debug_counter_bank_if
  import debug_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic                rd_req;
  logic [CH_SEL_W-1:0] rd_ch;
  logic                rd_valid;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_err;

  modport master (
    output rd_req,
    output rd_ch,
    input  rd_valid,
    input  rd_data,
    input  rd_err
  );

  modport slave (
    input  rd_req,
    input  rd_ch,
    output rd_valid,
    output rd_data,
    output rd_err
  );

endinterface

// File: rtl/debug_counter_ch.sv
// One debug counter channel: count register plus sticky overflow flag,
// with clear > load > increment > hold priority.
module debug_counter_ch
  import debug_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CH_IDX     = 0,
  parameter int STEP_SHIFT = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(init_val(CH_IDX, STEP_SHIFT, WIDTH));

  // One extra bit so the carry out of the add is visible.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] inc_val;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    sum     = {1'b0, count} + {1'b0, STEP};
    inc_val = sum[WIDTH-1:0];
    if (sum[WIDTH] && (sat_mode == MODE_SAT)) begin
      inc_val = '1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= STEP;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= STEP;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= inc_val;
      if (sum[WIDTH]) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_counter_bank.sv
// Bank of N_CH debug counters for CPU bring-up, with load decode and a
// latency-1 registered read port returning the pre-update value of one channel.
module debug_counter_bank
  import debug_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int N_CH       = 4,
  parameter int STEP_SHIFT = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  freeze,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       sat_mode,
  input  logic [N_CH-1:0]       clr,
  input  logic                  load,
  input  logic [CH_SEL_W-1:0]   load_ch,
  input  logic [WIDTH-1:0]      load_val,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       ovf,
  debug_counter_bank_if.slave   rd
);

  if (N_CH < 1 || N_CH > 8 || (N_CH - 1) * STEP_SHIFT >= WIDTH) begin : g_bad_cfg
    $error("debug_counter_bank: unsupported N_CH/STEP_SHIFT/WIDTH combination");
  end

  logic [WIDTH-1:0] ch_count [N_CH];
  logic [N_CH-1:0]  load_hit;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Loads aimed at a channel index beyond N_CH never match and are dropped.
    assign load_hit[i] = load && (load_ch == CH_SEL_W'(i));

    debug_counter_ch #(
      .WIDTH      (WIDTH),
      .CH_IDX     (i),
      .STEP_SHIFT (STEP_SHIFT)
    ) u_ch (
      .CLK      (CLK),
      .Reset    (Reset),
      .clr      (clr[i]),
      .load     (load_hit[i]),
      .load_val (load_val),
      .inc      (en[i] && !freeze),
      .sat_mode (sat_mode[i]),
      .count    (ch_count[i]),
      .ovf      (ovf[i])
    );

    assign count[i*WIDTH +: WIDTH] = ch_count[i];
  end

  logic [WIDTH-1:0] rd_mux;
  logic             rd_hit;

  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd.rd_ch == CH_SEL_W'(i)) begin
        rd_mux = ch_count[i];
        rd_hit = 1'b1;
      end
    end
  end

  // Sampling the live counters gives the value held before this edge's update.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_err   <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      if (rd.rd_req) begin
        rd.rd_data <= rd_mux;
        rd.rd_err  <= !rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_debug_counter_bank.sv
// Directed self-checking bench for debug_counter_bank (WIDTH=16, N_CH=4, STEP_SHIFT=4).
module tb_debug_counter_bank;

  localparam int WIDTH = 16;
  localparam int N_CH  = 4;

  logic                  CLK = 1'b0;
  logic                  Reset;
  logic                  freeze;
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       sat_mode;
  logic [N_CH-1:0]       clr;
  logic                  load;
  logic [2:0]            load_ch;
  logic [WIDTH-1:0]      load_val;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  debug_counter_bank_if #(.WIDTH(WIDTH)) rd_bus ();

  debug_counter_bank #(
    .WIDTH      (WIDTH),
    .N_CH       (N_CH),
    .STEP_SHIFT (4)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .freeze   (freeze),
    .en       (en),
    .sat_mode (sat_mode),
    .clr      (clr),
    .load     (load),
    .load_ch  (load_ch),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .rd       (rd_bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset         = 1'b1;
    freeze        = 1'b0;
    en            = '0;
    sat_mode      = '0;
    clr           = '0;
    load          = 1'b0;
    load_ch       = '0;
    load_val      = '0;
    rd_bus.rd_req = 1'b0;
    rd_bus.rd_ch  = '0;
    #2;
    check("reset_count", count, 64'h1000_0100_0010_0001);
    check("reset_ovf", 64'(ovf), 64'h0);
    check("reset_rd_valid", 64'(rd_bus.rd_valid), 64'h0);
    check("reset_rd_data", 64'(rd_bus.rd_data), 64'h0);
    check("reset_rd_err", 64'(rd_bus.rd_err), 64'h0);
    #10 Reset = 1'b0;

    // 1. All channels count three times.
    en = 4'hF;
    repeat (3) step();
    en = '0;
    check("t1_count", count, 64'h4000_0400_0040_0004);
    check("t1_ovf", 64'(ovf), 64'h0);

    // 2. Wrap on channel 0.
    load = 1'b1; load_ch = 3'd0; load_val = 16'hFFFE;
    step();
    load = 1'b0; en = 4'h1; sat_mode = 4'h0;
    step();
    check("t2_ch0_e1", 64'(count[15:0]), 64'hFFFF);
    check("t2_ovf_e1", 64'(ovf), 64'h0);
    step();
    check("t2_ch0_e2", 64'(count[15:0]), 64'h0000);
    check("t2_ovf_e2", 64'(ovf), 64'h1);
    step();
    check("t2_ch0_e3", 64'(count[15:0]), 64'h0001);
    check("t2_ovf_e3", 64'(ovf), 64'h1);
    en = '0;

    // 3. Saturate on channel 3, then clear it.
    load = 1'b1; load_ch = 3'd3; load_val = 16'hE000;
    step();
    load = 1'b0; sat_mode = 4'h8; en = 4'h8;
    step();
    check("t3_ch3_e1", 64'(count[63:48]), 64'hF000);
    check("t3_ovf_e1", 64'(ovf), 64'h1);
    step();
    check("t3_ch3_e2", 64'(count[63:48]), 64'hFFFF);
    check("t3_ovf_e2", 64'(ovf), 64'h9);
    step();
    check("t3_ch3_e3", 64'(count[63:48]), 64'hFFFF);
    check("t3_ovf_e3", 64'(ovf), 64'h9);
    en = '0; clr = 4'h8;
    step();
    clr = '0;
    check("t3_clr_ch3", 64'(count[63:48]), 64'h1000);
    check("t3_clr_ovf", 64'(ovf), 64'h1);

    // 4. Priority: clear beats load beats increment; freeze blocks increment only.
    clr = 4'h2; load = 1'b1; load_ch = 3'd1; load_val = 16'h1234; en = 4'h2;
    step();
    clr = '0;
    check("t4_clr_wins", 64'(count[31:16]), 64'h0010);
    freeze = 1'b1;
    step();
    load = 1'b0;
    check("t4_frozen_load", 64'(count[31:16]), 64'h1234);
    repeat (2) step();
    check("t4_frozen_hold", 64'(count[31:16]), 64'h1234);
    freeze = 1'b0; en = '0;

    // 5. Read port.
    load = 1'b1; load_ch = 3'd2; load_val = 16'h0100;
    step();
    load = 1'b0; en = 4'h4; rd_bus.rd_req = 1'b1; rd_bus.rd_ch = 3'd2;
    step();
    en = '0;
    check("t5_ch2_inc", 64'(count[47:32]), 64'h0200);
    check("t5_rd_valid", 64'(rd_bus.rd_valid), 64'h1);
    check("t5_rd_data_pre", 64'(rd_bus.rd_data), 64'h0100);
    check("t5_rd_err", 64'(rd_bus.rd_err), 64'h0);
    rd_bus.rd_ch = 3'd5;
    step();
    check("t5_oob_valid", 64'(rd_bus.rd_valid), 64'h1);
    check("t5_oob_data", 64'(rd_bus.rd_data), 64'h0);
    check("t5_oob_err", 64'(rd_bus.rd_err), 64'h1);
    rd_bus.rd_req = 1'b0;
    step();
    check("t5_idle_valid", 64'(rd_bus.rd_valid), 64'h0);
    check("t5_idle_err_hold", 64'(rd_bus.rd_err), 64'h1);
    rd_bus.rd_req = 1'b1; rd_bus.rd_ch = 3'd1;
    step();
    rd_bus.rd_ch = 3'd3;
    check("t5_b2b_data1", 64'(rd_bus.rd_data), 64'h1234);
    step();
    rd_bus.rd_req = 1'b0;
    check("t5_b2b_valid2", 64'(rd_bus.rd_valid), 64'h1);
    check("t5_b2b_data2", 64'(rd_bus.rd_data), 64'h1000);
    step();
    check("t5_idle_data_hold", 64'(rd_bus.rd_data), 64'h1000);
    load = 1'b1; load_ch = 3'd5; load_val = 16'hAAAA;
    step();
    load = 1'b0;
    check("t5_load_oob_ignored", count, 64'h1000_0200_1234_0001);

    // 6. Asynchronous reset mid-cycle with a read in flight.
    en = 4'hF; rd_bus.rd_req = 1'b1; rd_bus.rd_ch = 3'd0;
    step();
    check("t6_pre_rd_data", 64'(rd_bus.rd_data), 64'h0001);
    #2 Reset = 1'b1;
    #1;
    check("t6_async_count", count, 64'h1000_0100_0010_0001);
    check("t6_async_ovf", 64'(ovf), 64'h0);
    check("t6_async_rd_valid", 64'(rd_bus.rd_valid), 64'h0);
    check("t6_async_rd_data", 64'(rd_bus.rd_data), 64'h0);
    step();
    Reset = 1'b0;
    step();
    check("t6_resume_count", count, 64'h2000_0200_0020_0002);
    check("t6_resume_rd_valid", 64'(rd_bus.rd_valid), 64'h1);
    check("t6_resume_rd_data", 64'(rd_bus.rd_data), 64'h0001);
    en = '0; rd_bus.rd_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
